ldst_mmio_bridge: RTL
=====================

Name: ldst_mmio_bridge

Overview:
- Sits directly downstream of the CPU load/store port; consumes the CPU's ldst address/rd/wr/wrdata outputs and produces ldst read data.
- Decodes each access to either the external synchronous data RAM or an internal memory-mapped I/O bank: LED register, synchronized switch input, and a prescaled 16-bit timer with compare/match flag.
- Preserves the CPU's fixed one-cycle load latency for both RAM and MMIO reads, so the execute stage needs no wait states.

Parameters:
MMIO_BASE, 16'hF000, base of the MMIO window; addresses >= MMIO_BASE are MMIO, all others are RAM
PRESCALE, 50000, clk cycles per timer tick (>=1)
SW_WIDTH, 10, switch input width (1..16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_ldst_addr  in  16  byte address from CPU; bit0 ignored
i_ldst_rd  in  1  read strobe, one cycle per load
i_ldst_wr  in  1  write strobe, one cycle per store
i_ldst_wrdata  in  16  store data
o_ldst_rddata  out  16  load data, valid the cycle after i_ldst_rd
o_ram_addr  out  16  RAM address (i_ldst_addr passthrough)
o_ram_rd  out  1  RAM read strobe
o_ram_wr  out  1  RAM write strobe
o_ram_wrdata  out  16  RAM write data (i_ldst_wrdata passthrough)
i_ram_rddata  in  16  RAM read data, valid one cycle after o_ram_rd
i_sw  in  SW_WIDTH  asynchronous switch inputs
o_led  out  16  LED register
o_tmr_match  out  1  sticky timer match flag (status bit0)

Behaviour:
- Clock is clk. Reset is asynchronous and active-high; no other reset style is used.
- Reset values:
  - led = 0, rddata register = 0, read-select register = RAM.
  - count = 0, prescaler = 0, ctrl = 0, compare = 16'hFFFF, match = 0.
  - Both switch synchronizer stages = 0.
- Decode (combinational): is_mmio = (i_ldst_addr >= MMIO_BASE).
  - o_ram_rd = i_ldst_rd & ~is_mmio & ~i_ldst_wr.
  - o_ram_wr = i_ldst_wr & ~is_mmio.
  - No RAM strobes are ever issued for MMIO addresses.
- MMIO map (offset = addr - MMIO_BASE, bit0 ignored):
  - 0x0 LED: RW.
  - 0x2 SW: RO, zero-extended synchronized i_sw.
  - 0x4 COUNT: RO.
  - 0x6 CTRL: RW; bit0 = enable, bit1 = clear (write-only, reads 0); other bits read 0.
  - 0x8 COMPARE: RW.
  - 0xA STATUS: bit0 = match; writing 1 to bit0 clears match.
  - Any other offset reads 0x0000 and ignores writes.
- Read path: on a read cycle, register sel <= {is_mmio, offset}.
  - MMIO read: capture the MMIO read data into the rddata register at the same edge.
  - RAM read: next cycle o_ldst_rddata = i_ram_rddata (mux controlled by the registered sel).
  - Latency is exactly 1 cycle in both cases.
  - o_ldst_rddata holds its last value until the next read. For a RAM read, holding relies on the RAM holding its output; the bench RAM model must do so.
- Simultaneous i_ldst_rd and i_ldst_wr: the write is performed, the read is ignored, and sel/rddata are unchanged.
- Back-to-back reads (one per cycle) are fully supported. A read of a register in the cycle after a write to it returns the new value.
- Switch sync: two flops. A change on i_sw is visible in an SW read issued 2 cycles after it, and on o_ldst_rddata 3 cycles after it.
- Timer:
  - While ctrl.enable = 1, the prescaler counts 0..PRESCALE-1 and wraps.
  - On each wrap, count increments modulo 2^16 (0xFFFF -> 0x0000, no flag).
  - If the incremented count equals compare, match <= 1 (sticky).
  - enable = 0 freezes both the prescaler and count.
  - A CTRL write with bit1 = 1 zeroes count and prescaler in that cycle and takes priority over the increment. The enable bit is updated from the same write.
  - If a STATUS clear and a match set occur in the same cycle, set wins.
  - A COMPARE write takes effect for the next increment; an existing equality does not retroactively set match.
- o_tmr_match = match.
- Reset asserted mid-operation returns all state to reset values immediately. The RAM strobes follow the (combinational) inputs regardless of reset.

Test Plan:
- Reset, then RAM read at 0x0100 with the RAM model returning 0x1234 -> o_ram_rd=1 in the request cycle, o_ldst_rddata=0x1234 the next cycle, held after rd drops.
- Write 0x00A5 to 0xF000, read 0xF000 in the next cycle -> o_led=0x00A5, o_ram_wr never asserted, o_ldst_rddata=0x00A5 one cycle after the read.
- i_sw=10'h2AA set, read 0xF002 issued 2 cycles later -> o_ldst_rddata=0x02AA one cycle after the read (3 cycles after the i_sw change); read 0xF00C -> 0x0000.
- PRESCALE=4: write COMPARE=3, write CTRL=1 -> COUNT reads 3 after 12 enabled cycles and o_tmr_match=1. Write STATUS=1 -> match=0. Write CTRL=3 -> COUNT=0 and counting continues.
- Preload count to 0xFFFF (by running the timer), with compare=0x0005 -> the next tick gives COUNT=0x0000 and match stays 0.
- Simultaneous rd+wr to 0xF008 with data 0x0042 -> COMPARE=0x0042 and o_ldst_rddata unchanged. Assert reset mid-count -> all registers back to reset values asynchronously, COMPARE reads 0xFFFF.

Source files
------------

// File: rtl/ldst_mmio_bridge.sv
// Load/store bridge: routes CPU accesses to external RAM or the MMIO bank
// (LED, synchronized switches, prescaled timer) with a fixed 1-cycle load latency.
module ldst_mmio_bridge #(
  parameter logic [15:0] MMIO_BASE = 16'hF000,
  parameter int          PRESCALE  = 50000,
  parameter int          SW_WIDTH  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         i_ldst_addr,
  input  logic                i_ldst_rd,
  input  logic                i_ldst_wr,
  input  logic [15:0]         i_ldst_wrdata,
  output logic [15:0]         o_ldst_rddata,
  output logic [15:0]         o_ram_addr,
  output logic                o_ram_rd,
  output logic                o_ram_wr,
  output logic [15:0]         o_ram_wrdata,
  input  logic [15:0]         i_ram_rddata,
  input  logic [SW_WIDTH-1:0] i_sw,
  output logic [15:0]         o_led,
  output logic                o_tmr_match
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [15:0]         r_led;
  logic [15:0]         r_rddata;
  logic                r_sel_mmio;
  logic [15:0]         r_count;
  logic [PW-1:0]       r_pre;
  logic                r_en;
  logic [15:0]         r_cmp;
  logic                r_match;
  logic [SW_WIDTH-1:0] r_sw_meta;
  logic [SW_WIDTH-1:0] r_sw_sync;

  logic        w_is_mmio;
  logic [14:0] w_word;
  logic        w_rd_ok;
  logic        w_wr_mmio;
  logic        w_wr_led;
  logic        w_wr_ctrl;
  logic        w_wr_cmp;
  logic        w_wr_stat;
  logic        w_clr;
  logic        w_tick;
  logic [15:0] w_cnt_inc;
  logic        w_set;
  logic [15:0] w_sw16;
  logic [15:0] w_mmio_rd;

  assign w_is_mmio = (i_ldst_addr >= MMIO_BASE);
  assign w_word    = i_ldst_addr[15:1] - MMIO_BASE[15:1];
  assign w_rd_ok   = i_ldst_rd & ~i_ldst_wr;

  assign o_ram_addr   = i_ldst_addr;
  assign o_ram_wrdata = i_ldst_wrdata;
  assign o_ram_rd     = w_rd_ok & ~w_is_mmio;
  assign o_ram_wr     = i_ldst_wr & ~w_is_mmio;

  assign w_wr_mmio = i_ldst_wr & w_is_mmio;
  assign w_wr_led  = w_wr_mmio & (w_word == 15'd0);
  assign w_wr_ctrl = w_wr_mmio & (w_word == 15'd3);
  assign w_wr_cmp  = w_wr_mmio & (w_word == 15'd4);
  assign w_wr_stat = w_wr_mmio & (w_word == 15'd5);
  assign w_clr     = w_wr_ctrl & i_ldst_wrdata[1];

  assign w_tick    = r_en & (r_pre == PRE_LAST);
  assign w_cnt_inc = r_count + 16'd1;
  // Compare uses the pre-write value, so a same-cycle COMPARE write is not retroactive
  assign w_set     = w_tick & ~w_clr & (w_cnt_inc == r_cmp);

  assign w_sw16 = 16'(r_sw_sync);

  always_comb begin
    w_mmio_rd = 16'h0000;
    case (w_word)
      15'd0:   w_mmio_rd = r_led;
      15'd1:   w_mmio_rd = w_sw16;
      15'd2:   w_mmio_rd = r_count;
      15'd3:   w_mmio_rd = {15'h0, r_en};
      15'd4:   w_mmio_rd = r_cmp;
      15'd5:   w_mmio_rd = {15'h0, r_match};
      default: w_mmio_rd = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led      <= 16'h0000;
      r_cmp      <= 16'hFFFF;
      r_rddata   <= 16'h0000;
      r_sel_mmio <= 1'b0;
    end else begin
      if (w_wr_led) r_led <= i_ldst_wrdata;
      if (w_wr_cmp) r_cmp <= i_ldst_wrdata;
      if (w_rd_ok) begin
        r_sel_mmio <= w_is_mmio;
        if (w_is_mmio) r_rddata <= w_mmio_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_pre   <= '0;
      r_count <= 16'h0000;
      r_match <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_en <= i_ldst_wrdata[0];
      if (w_clr) begin
        r_pre   <= '0;
        r_count <= 16'h0000;
      end else if (r_en) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick) r_count <= w_cnt_inc;
      end
      if (w_set) r_match <= 1'b1;
      else if (w_wr_stat & i_ldst_wrdata[0]) r_match <= 1'b0;
    end
  end

  // RAM data is not registered here; the RAM itself supplies the 1-cycle latency
  assign o_ldst_rddata = r_sel_mmio ? r_rddata : i_ram_rddata;
  assign o_led         = r_led;
  assign o_tmr_match   = r_match;

endmodule
